// File: rtl/algo_mrpnwp_1r1w_wrq_top.sv
// Multi-write / multi-read memory built from replicated 1R1W banks. Writes funnel through a
// queue drained one entry per cycle into every bank; reads bypass entries still in the queue.
module algo_mrpnwp_1r1w_wrq_top #(
  parameter int WIDTH      = 64,
  parameter int NUMADDR    = 8192,
  parameter int BITADDR    = 13,
  parameter int NUMRDPT    = 2,
  parameter int NUMWRPT    = 4,
  parameter int QDEPTH     = 16,
  parameter int BITQDEP    = 5,
  parameter int SRAM_DELAY = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       ready,
  input  logic [NUMWRPT-1:0]         write,
  input  logic [NUMWRPT*BITADDR-1:0] wr_adr,
  input  logic [NUMWRPT*WIDTH-1:0]   din,
  output logic                       wr_full,
  output logic                       wr_ovf,
  input  logic [NUMRDPT-1:0]         read,
  input  logic [NUMRDPT*BITADDR-1:0] rd_adr,
  output logic [NUMRDPT-1:0]         rd_vld,
  output logic [NUMRDPT*WIDTH-1:0]   rd_dout,
  output logic [NUMRDPT-1:0]         t1_writeA,
  output logic [NUMRDPT*BITADDR-1:0] t1_addrA,
  output logic [NUMRDPT*WIDTH-1:0]   t1_dinA,
  output logic [NUMRDPT-1:0]         t1_readB,
  output logic [NUMRDPT*BITADDR-1:0] t1_addrB,
  input  logic [NUMRDPT*WIDTH-1:0]   t1_doutB
);

  localparam int PTRW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  typedef enum logic {INIT, RUN} state_t;
  state_t state;
  logic [BITADDR-1:0] cnt;

  logic [BITADDR-1:0] q_adr [QDEPTH];
  logic [WIDTH-1:0]   q_dat [QDEPTH];
  logic [PTRW-1:0]    head, tail;
  logic [BITQDEP-1:0] count, count_nxt, push_cnt;
  logic [NUMWRPT-1:0] push_en;
  logic [PTRW-1:0]    push_idx [NUMWRPT];
  logic               pop;

  // Pointer arithmetic modulo QDEPTH; inputs never exceed 2*QDEPTH-1.
  function automatic logic [PTRW-1:0] qwrap(input int p);
    return (p >= QDEPTH) ? PTRW'(p - QDEPTH) : PTRW'(p);
  endfunction

  always_comb begin
    push_cnt = '0;
    for (int i = 0; i < NUMWRPT; i++) begin
      push_en[i]  = ready && !wr_full && write[i];
      push_idx[i] = qwrap(int'(tail) + int'(push_cnt));
      if (push_en[i]) push_cnt = push_cnt + 1'b1;
    end
  end

  assign pop       = ready && (count != '0);
  assign count_nxt = BITQDEP'(int'(count) + int'(push_cnt) - int'(pop));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= INIT;
      cnt     <= '0;
      ready   <= 1'b0;
      wr_full <= 1'b1;
      wr_ovf  <= 1'b0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
    end else if (state == INIT) begin
      cnt <= cnt + 1'b1;
      if (cnt == BITADDR'(NUMADDR - 1)) begin
        state   <= RUN;
        ready   <= 1'b1;
        wr_full <= QDEPTH < NUMWRPT;
      end
    end else begin
      if (pop) head <= qwrap(int'(head) + 1);
      tail    <= qwrap(int'(tail) + int'(push_cnt));
      count   <= count_nxt;
      wr_full <= (QDEPTH - int'(count_nxt)) < NUMWRPT;
      if (wr_full && (|write)) wr_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUMWRPT; i++)
      if (push_en[i]) begin
        q_adr[push_idx[i]] <= wr_adr[i*BITADDR +: BITADDR];
        q_dat[push_idx[i]] <= din[i*WIDTH +: WIDTH];
      end
  end

  // Bank write port: zero-fill sweep during INIT, queue head during RUN.
  logic               bank_we;
  logic [BITADDR-1:0] bank_adr;
  logic [WIDTH-1:0]   bank_dat;

  always_comb begin
    bank_we  = pop;
    bank_adr = q_adr[head];
    bank_dat = q_dat[head];
    if (state == INIT) begin
      bank_we  = !rst;
      bank_adr = cnt;
      bank_dat = '0;
    end
  end

  assign t1_writeA = {NUMRDPT{bank_we}};
  assign t1_addrA  = {NUMRDPT{bank_adr}};
  assign t1_dinA   = {NUMRDPT{bank_dat}};

  // Stage p0: read issue and bypass search over entries queued before this cycle.
  logic [NUMRDPT-1:0] vld_p0, hit_p0;
  logic [WIDTH-1:0]   byp_p0 [NUMRDPT];

  always_comb begin
    for (int i = 0; i < NUMRDPT; i++) begin
      vld_p0[i] = ready && read[i];
      hit_p0[i] = 1'b0;
      byp_p0[i] = q_dat[head];
      for (int k = 0; k < QDEPTH; k++)
        if (k < int'(count) && q_adr[qwrap(int'(head) + k)] == rd_adr[i*BITADDR +: BITADDR]) begin
          hit_p0[i] = 1'b1;
          byp_p0[i] = q_dat[qwrap(int'(head) + k)];
        end
    end
  end

  assign t1_readB = vld_p0;
  assign t1_addrB = rd_adr;

  // Stage p1: delay line matching the SRAM read latency.
  logic [NUMRDPT-1:0] vld_p1 [SRAM_DELAY];
  logic [NUMRDPT-1:0] hit_p1 [SRAM_DELAY];
  logic [WIDTH-1:0]   byp_p1 [SRAM_DELAY][NUMRDPT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SRAM_DELAY; s++) begin
        vld_p1[s] <= '0;
        hit_p1[s] <= '0;
      end
    end else begin
      vld_p1[0] <= vld_p0;
      hit_p1[0] <= hit_p0;
      for (int s = 1; s < SRAM_DELAY; s++) begin
        vld_p1[s] <= vld_p1[s-1];
        hit_p1[s] <= hit_p1[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    byp_p1[0] <= byp_p0;
    for (int s = 1; s < SRAM_DELAY; s++) byp_p1[s] <= byp_p1[s-1];
  end

  // Stage p2: registered read return; data holds while no read completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld  <= '0;
      rd_dout <= '0;
    end else begin
      rd_vld <= vld_p1[SRAM_DELAY-1];
      for (int i = 0; i < NUMRDPT; i++)
        if (vld_p1[SRAM_DELAY-1][i])
          rd_dout[i*WIDTH +: WIDTH] <= hit_p1[SRAM_DELAY-1][i] ? byp_p1[SRAM_DELAY-1][i]
                                                                : t1_doutB[i*WIDTH +: WIDTH];
    end
  end

endmodule

// File: tb/tb_algo_mrpnwp_1r1w_wrq_top.sv
// Bench for algo_mrpnwp_1r1w_wrq_top: architectural memory + pending-write model checked every
// cycle, plus directed vectors with hand-computed expectations.
`timescale 1ns/1ps
module tb_algo_mrpnwp_1r1w_wrq_top;
  localparam int WIDTH = 16, NUMADDR = 64, BITADDR = 6, NUMRDPT = 2, NUMWRPT = 4;
  localparam int QDEPTH = 16, BITQDEP = 5, SRAM_DELAY = 1;

  logic clk = 1'b0, rst = 1'b1;
  logic ready, wr_full, wr_ovf;
  logic [NUMWRPT-1:0]         write  = '0;
  logic [NUMWRPT*BITADDR-1:0] wr_adr = '0;
  logic [NUMWRPT*WIDTH-1:0]   din    = '0;
  logic [NUMRDPT-1:0]         read   = '0;
  logic [NUMRDPT*BITADDR-1:0] rd_adr = '0;
  logic [NUMRDPT-1:0]         rd_vld, t1_writeA, t1_readB;
  logic [NUMRDPT*WIDTH-1:0]   rd_dout, t1_dinA, t1_doutB;
  logic [NUMRDPT*BITADDR-1:0] t1_addrA, t1_addrB;

  int nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  algo_mrpnwp_1r1w_wrq_top #(
    .WIDTH(WIDTH), .NUMADDR(NUMADDR), .BITADDR(BITADDR), .NUMRDPT(NUMRDPT), .NUMWRPT(NUMWRPT),
    .QDEPTH(QDEPTH), .BITQDEP(BITQDEP), .SRAM_DELAY(SRAM_DELAY)
  ) dut (
    .clk(clk), .rst(rst), .ready(ready), .write(write), .wr_adr(wr_adr), .din(din),
    .wr_full(wr_full), .wr_ovf(wr_ovf), .read(read), .rd_adr(rd_adr), .rd_vld(rd_vld),
    .rd_dout(rd_dout), .t1_writeA(t1_writeA), .t1_addrA(t1_addrA), .t1_dinA(t1_dinA),
    .t1_readB(t1_readB), .t1_addrB(t1_addrB), .t1_doutB(t1_doutB)
  );

  // 1R1W banks with one cycle read latency; reads see contents before the same-edge write.
  logic [WIDTH-1:0] bank [NUMRDPT][NUMADDR];
  always @(posedge clk)
    for (int b = 0; b < NUMRDPT; b++) begin
      if (t1_readB[b]) t1_doutB[b*WIDTH +: WIDTH] <= bank[b][t1_addrB[b*BITADDR +: BITADDR]];
      if (t1_writeA[b]) bank[b][t1_addrA[b*BITADDR +: BITADDR]] <= t1_dinA[b*WIDTH +: WIDTH];
    end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Model: arch holds every accepted write; pend lists writes not yet drained to the banks.
  typedef struct packed {logic [BITADDR-1:0] a; logic [WIDTH-1:0] d;} ent_t;
  ent_t pend[$];
  logic [WIDTH-1:0] arch [NUMADDR];
  bit m_ready = 0, m_full = 1, m_ovf = 0, pre_ready, pre_full;
  int init_cnt = 0;
  logic [NUMRDPT-1:0] st_v [SRAM_DELAY+1];
  logic [WIDTH-1:0]   st_d [SRAM_DELAY+1][NUMRDPT];
  logic [NUMRDPT-1:0] nv;
  logic [WIDTH-1:0]   nd [NUMRDPT];
  logic [NUMRDPT-1:0] exp_vld = '0;
  logic [NUMRDPT*WIDTH-1:0] exp_dout = '0;

  always @(posedge clk) begin
    if (rst) begin
      pend.delete();
      for (int a = 0; a < NUMADDR; a++) arch[a] = '0;
      m_ready = 0; m_full = 1; m_ovf = 0; init_cnt = 0;
      for (int k = 0; k <= SRAM_DELAY; k++) st_v[k] = '0;
      exp_vld = '0; exp_dout = '0;
    end else begin
      pre_ready = m_ready;
      pre_full  = m_full;
      for (int i = 0; i < NUMRDPT; i++) begin
        nv[i] = pre_ready && read[i];
        nd[i] = arch[rd_adr[i*BITADDR +: BITADDR]];
      end
      if (pre_ready && pend.size() > 0) void'(pend.pop_front());
      if (pre_ready && (|write)) begin
        if (pre_full) m_ovf = 1;
        else
          for (int i = 0; i < NUMWRPT; i++)
            if (write[i]) begin
              arch[wr_adr[i*BITADDR +: BITADDR]] = din[i*WIDTH +: WIDTH];
              pend.push_back(ent_t'({wr_adr[i*BITADDR +: BITADDR], din[i*WIDTH +: WIDTH]}));
            end
      end
      if (!pre_ready) begin
        if (init_cnt == NUMADDR - 1) m_ready = 1;
        else init_cnt++;
      end
      m_full = m_ready ? ((QDEPTH - pend.size()) < NUMWRPT) : 1'b1;
      for (int k = SRAM_DELAY; k > 0; k--) begin
        st_v[k] = st_v[k-1];
        st_d[k] = st_d[k-1];
      end
      st_v[0] = nv;
      st_d[0] = nd;
      exp_vld = st_v[SRAM_DELAY];
      for (int i = 0; i < NUMRDPT; i++)
        if (exp_vld[i]) exp_dout[i*WIDTH +: WIDTH] = st_d[SRAM_DELAY][i];
    end
  end

  logic exp_we;
  logic [BITADDR-1:0] ea;
  logic [WIDTH-1:0] ed;
  always @(posedge clk) begin
    #2;
    chk("ready", ready, m_ready);
    chk("wr_full", wr_full, m_full);
    chk("wr_ovf", wr_ovf, m_ovf);
    chk("rd_vld", rd_vld, exp_vld);
    chk("rd_dout", rd_dout, exp_dout);
    exp_we = rst ? 1'b0 : (!m_ready || pend.size() > 0);
    chk("t1_writeA", t1_writeA, {NUMRDPT{exp_we}});
    if (exp_we) begin
      if (!m_ready) begin ea = BITADDR'(init_cnt); ed = '0; end
      else begin ea = pend[0].a; ed = pend[0].d; end
      chk("t1_addrA", t1_addrA, {NUMRDPT{ea}});
      chk("t1_dinA", t1_dinA, {NUMRDPT{ed}});
    end
  end

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 1000) begin
      @(posedge clk); #3;
      n++;
    end
  endtask

  task automatic do_read(input int p, input int a, output logic v, output logic [WIDTH-1:0] d);
    @(negedge clk);
    read[p] = 1'b1;
    rd_adr[p*BITADDR +: BITADDR] = BITADDR'(a);
    @(negedge clk);
    read = '0;
    @(posedge clk); #3;
    v = rd_vld[p];
    d = rd_dout[p*WIDTH +: WIDTH];
  endtask

  int n, npulse;
  logic v;
  logic [WIDTH-1:0] d;
  logic [3*BITADDR-1:0] seq;
  logic [3:0] fulls;

  initial begin
    repeat (3) @(posedge clk);
    #3;
    chk("rst_ready", ready, 0);
    chk("rst_wr_full", wr_full, 1);
    chk("rst_wr_ovf", wr_ovf, 0);
    chk("rst_rd_vld", rd_vld, 0);
    chk("rst_rd_dout", rd_dout, 0);
    chk("rst_writeA", t1_writeA, 0);
    @(negedge clk); rst = 1'b0;
    wait_ready(n);
    chk("init_len", n, NUMADDR);
    do_read(0, 5, v, d);
    chk("rd_adr5", {v, d}, {1'b1, 16'h0});

    // Four ports in one cycle, drained over four cycles in port order.
    @(negedge clk);
    write = 4'hF;
    wr_adr = {6'd4, 6'd3, 6'd2, 6'd1};
    din = {16'hD, 16'hC, 16'hB, 16'hA};
    @(negedge clk); write = '0;
    npulse = 0; seq = '0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      if (t1_writeA != '0) begin
        npulse++;
        seq = {seq[2*BITADDR-1:0], t1_addrA[BITADDR-1:0]};
      end
    end
    chk("multi_pulses", npulse, 4);
    chk("multi_order", seq, {6'd2, 6'd3, 6'd4});
    do_read(0, 1, v, d); chk("multi_rd1", {v, d}, {1'b1, 16'hA});
    do_read(1, 2, v, d); chk("multi_rd2", {v, d}, {1'b1, 16'hB});
    do_read(0, 3, v, d); chk("multi_rd3", {v, d}, {1'b1, 16'hC});
    do_read(1, 4, v, d); chk("multi_rd4", {v, d}, {1'b1, 16'hD});

    // Same-address conflict: highest port wins.
    @(negedge clk);
    write = 4'b1001;
    wr_adr = {6'd7, 12'd0, 6'd7};
    din = {16'h33, 32'h0, 16'h11};
    @(negedge clk); write = '0;
    repeat (4) @(negedge clk);
    do_read(1, 7, v, d); chk("conflict", {v, d}, {1'b1, 16'h33});

    // Bypass: read one cycle after the write, entry still queued.
    @(negedge clk);
    write = 4'b0001; wr_adr[5:0] = 6'd9; din[15:0] = 16'hAB;
    @(negedge clk);
    write = '0; read = 2'b01; rd_adr[5:0] = 6'd9;
    @(negedge clk); read = '0;
    @(posedge clk); #3;
    chk("bypass", {rd_vld[0], rd_dout[15:0]}, {1'b1, 16'hAB});

    // Write and read of the same address in one cycle: the read sees the old value.
    repeat (3) @(negedge clk);
    @(negedge clk);
    write = 4'b0010; wr_adr[11:6] = 6'd9; din[31:16] = 16'hCD;
    read = 2'b10; rd_adr[11:6] = 6'd9;
    @(negedge clk); write = '0; read = '0;
    @(posedge clk); #3;
    chk("same_cycle", {rd_vld[1], rd_dout[31:16]}, {1'b1, 16'hAB});
    do_read(0, 9, v, d); chk("same_cycle_later", {v, d}, {1'b1, 16'hCD});

    // Fill: counts 4, 7, 10, 13 after each 4-port cycle; full once free < 4.
    repeat (2) @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      write = 4'hF;
      for (int i = 0; i < NUMWRPT; i++) begin
        wr_adr[i*BITADDR +: BITADDR] = BITADDR'(20 + 4*c + i);
        din[i*WIDTH +: WIDTH] = WIDTH'(256 + 4*c + i);
      end
      @(posedge clk); #3;
      fulls[c] = wr_full;
    end
    chk("full_after3", fulls[2], 0);
    chk("full_after4", fulls[3], 1);
    @(negedge clk);
    write = 4'b0001; wr_adr[5:0] = 6'd40; din[15:0] = 16'hDEAD;
    @(posedge clk); #3;
    chk("ovf_set", wr_ovf, 1);
    @(negedge clk); write = '0;
    n = 0;
    while (wr_full && n < 50) begin @(negedge clk); n++; end
    chk("full_clear", wr_full, 0);
    repeat (16) @(negedge clk);
    do_read(0, 40, v, d); chk("ovf_dropped", {v, d}, {1'b1, 16'h0});
    do_read(1, 35, v, d); chk("fill_rd35", {v, d}, {1'b1, 16'h10F});
    chk("ovf_sticky", wr_ovf, 1);

    // Reset with 10 entries queued.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      write = 4'hF;
      for (int i = 0; i < NUMWRPT; i++) begin
        wr_adr[i*BITADDR +: BITADDR] = BITADDR'(48 + 4*c + i);
        din[i*WIDTH +: WIDTH] = WIDTH'(512 + 4*c + i);
      end
    end
    @(negedge clk); write = '0; rst = 1'b1;
    #1;
    chk("midrst_ready", ready, 0);
    chk("midrst_full", wr_full, 1);
    chk("midrst_ovf", wr_ovf, 0);
    chk("midrst_we", t1_writeA, 0);
    repeat (2) @(negedge clk); rst = 1'b0;
    wait_ready(n);
    chk("reinit_len", n, NUMADDR);
    for (int a = 0; a < NUMADDR; a++) begin
      do_read(a % NUMRDPT, a, v, d);
      chk($sformatf("post_rst_rd%0d", a), {v, d}, {1'b1, 16'h0});
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal;
  end

endmodule
